// File: rtl/lvdc_mem_pkg.sv
// lvdc_mem_pkg: shared FSM state type, default geometry constants and the syllable-merge helper
package lvdc_mem_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;
  localparam int DEF_AW = 15;
  localparam int DEF_DW = 26;
  localparam int DEF_NSYL = 2;
  localparam int MAXW = 64;
  localparam int MAXS = 8;
  function automatic logic [MAXW-1:0] syl_merge(input logic [MAXW-1:0] old_w, input logic [MAXW-1:0] new_w,
                                                input logic [MAXS-1:0] mask, input int sw);
    logic [MAXW-1:0] m;
    m = '0;
    for (int s = 0; s < MAXS; s++)
      for (int b = 0; b < sw; b++)
        if (s * sw + b < MAXW) m[s * sw + b] = mask[s];
    return (old_w & ~m) | (new_w & m);
  endfunction
endpackage

// File: rtl/lvdc_mem_ws_rst_stretch.sv
// lvdc_rst_stretch: holds cpu_rst high for N clk edges after async rst (in: clk, rst; out: cpu_rst)
module lvdc_rst_stretch #(
  parameter int N = 3
) (
  input  logic clk,
  input  logic rst,
  output logic cpu_rst
);
  localparam int CW = $clog2(N + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= CW'(N);
      cpu_rst <= 1'b1;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      cpu_rst <= cnt != CW'(1);
    end
endmodule

// File: rtl/lvdc_mem_ws.sv
// lvdc_mem_ws: wait-state memory with syllable write mask (in: clk rst req we wmask addr wdata; out: cpu_rst rdata ready busy err)
module lvdc_mem_ws
  import lvdc_mem_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int NSYL = DEF_NSYL,
  parameter int DEPTH = 32768,
  parameter int WAIT = 0,
  parameter int RST_STRETCH = 3,
  parameter string INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            rst,
  output logic            cpu_rst,
  input  logic            req,
  input  logic            we,
  input  logic [NSYL-1:0] wmask,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata,
  output logic            ready,
  output logic            busy,
  output logic            err
);
  localparam int SW = DW / NSYL;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  state_t state;
  logic [AW-1:0] addr_q, a_n;
  logic we_q, we_n, rng_n, go_done, in_range;
  logic [NSYL-1:0] wmask_q;
  logic [DW-1:0] wdata_q;
  logic [3:0] wait_cnt;
  lvdc_rst_stretch #(.N(RST_STRETCH)) u_rst_stretch (.clk(clk), .rst(rst), .cpu_rst(cpu_rst));
  always_comb begin
    a_n = state == ST_IDLE ? addr : addr_q;
    we_n = state == ST_IDLE ? we : we_q;
    rng_n = {1'b0, a_n} < DEPTH_L;
    go_done = (state == ST_IDLE && req && !cpu_rst && WAIT == 0) || (state == ST_WAIT && wait_cnt == 4'd1);
    in_range = {1'b0, addr_q} < DEPTH_L;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      ready <= 1'b0;
      busy <= 1'b0;
      err <= 1'b0;
      rdata <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
      wmask_q <= '0;
      wdata_q <= '0;
      wait_cnt <= '0;
    end else begin
      ready <= go_done;
      err <= go_done && !rng_n;
      if (go_done && !we_n) rdata <= rng_n ? mem[a_n[IW-1:0]] : '0;
      case (state)
        ST_IDLE: if (req && !cpu_rst) begin
          addr_q <= addr;
          we_q <= we;
          wmask_q <= wmask;
          wdata_q <= wdata;
          wait_cnt <= 4'(WAIT);
          state <= WAIT > 0 ? ST_WAIT : ST_DONE;
          busy <= 1'b1;
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  always_ff @(posedge clk)
    if (!rst && state == ST_DONE && we_q && in_range)
      mem[addr_q[IW-1:0]] <= DW'(syl_merge(MAXW'(mem[addr_q[IW-1:0]]), MAXW'(wdata_q), MAXS'(wmask_q), SW));
endmodule
